chaser_sequencer: RTL and testbench
===================================

CHASER_SEQUENCER -- requirements
Module: chaser_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the one-hot pattern width (minimum 2).
REQ-002 Parameter DIV_W, default 16, SHALL set the tick period counter and register width.
REQ-003 Parameter DEF_PERIOD, default 4, SHALL set the period register reset value.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port resetn, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-006 Port cmd_valid, input, 1 bit, SHALL indicate a command is offered.
REQ-007 Port cmd_ready, output, 1 bit, SHALL indicate the block can accept a command this cycle.
REQ-008 Port cmd_op, input, 2 bits, SHALL encode the command: 0=STOP, 1=START, 2=SET_PERIOD, 3=SET_DIR.
REQ-009 Port cmd_arg, input, DIV_W bits, SHALL carry the operand: the period for SET_PERIOD; bit0 = direction and bit1 = bounce for SET_DIR.
REQ-010 Port led, output, WIDTH bits, SHALL carry the registered one-hot pattern.
REQ-011 Port stb_out, output, 1 bit, SHALL pulse for one cycle, aligned with each led update.
REQ-012 Port busy, output, 1 bit, SHALL be high while the state is RUN.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-014 The block SHALL accept a command when cmd_valid and cmd_ready are both high at a rising edge; the command SHALL take effect at that edge.
REQ-015 The internal signal tick SHALL be combinational: high when state==RUN and cnt==period.
REQ-016 cmd_ready SHALL equal !tick (low only in a tick cycle), so a command never coincides with a rotation.
REQ-017 In RUN with no tick, cnt SHALL increment by 1; on a tick, cnt SHALL clear to 0, led SHALL advance one position, and stb_out SHALL be 1 in the following cycle.
REQ-018 In IDLE, cnt SHALL hold 0 and led SHALL hold its value.
REQ-019 Period 0 SHALL produce a tick in every RUN cycle; the tick interval SHALL be period+1 cycles.
REQ-020 An accepted START in IDLE SHALL move the FSM to RUN with cnt=0; the first led change SHALL appear period+1 cycles after acceptance; START in RUN SHALL be ignored.
REQ-021 An accepted STOP in RUN SHALL move the FSM to IDLE, clear cnt, and freeze led; STOP in IDLE SHALL have no effect.
REQ-022 An accepted SET_PERIOD SHALL load period from cmd_arg and clear cnt, without changing state.
REQ-023 An accepted SET_DIR SHALL load dir from cmd_arg[0]; dir=0 SHALL rotate toward the MSB (bit WIDTH-1 wraps to bit0), and dir=1 SHALL rotate toward the LSB (bit0 wraps to bit WIDTH-1).
REQ-024 led SHALL remain one-hot at all times.

Reset
REQ-025 Asserting resetn low SHALL, at any time and independent of clk, force: state=IDLE, cnt=0, period=DEF_PERIOD, dir=0, bounce=0, led=1 (bit0), stb_out=0.
REQ-026 After reset is released, busy SHALL be 0 and cmd_ready SHALL be 1.
REQ-027 A reset asserted during RUN SHALL abandon the sequence; no stb_out SHALL follow.

Configuration
REQ-028 With macro CHASER_BOUNCE_EN defined, SET_DIR SHALL load bounce from cmd_arg[1].
REQ-029 With bounce=1, a tick at an end position SHALL reverse dir and move led one position back instead of wrapping; the sequence for WIDTH=4 from 0001 with dir=0 SHALL be 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
REQ-030 Without CHASER_BOUNCE_EN, cmd_arg[1] SHALL be ignored, bounce logic SHALL not be synthesized, and rotation SHALL always wrap.

Verification
REQ-031 Reset check: after reset (WIDTH=8), START at cycle 0 -> led=0x01 through cycle 5, led=0x02 with stb_out=1 at cycle 6, then led=0x04 at cycle 11.
REQ-032 Period check: SET_PERIOD 0 then START -> led advances every cycle, 0x80->0x01 wrap occurs, and cmd_ready stays low in every RUN cycle.
REQ-033 Stop check: STOP accepted in RUN when led=0x08 -> busy=0 the next cycle, and led stays 0x08 for 50 cycles with no stb_out.
REQ-034 Direction check: SET_DIR arg=1 in RUN at led=0x01 -> next ticks give 0x80, then 0x40.
REQ-035 Bounce check (CHASER_BOUNCE_EN, WIDTH=4): SET_DIR arg=2, START -> led sequence 2,4,8,4,2,1,2.
REQ-036 Mid-run reset check: assert resetn between clock edges in RUN -> led=0x01, busy=0, and stb_out=0 immediately, with no further ticks after release.

Source files
------------

// File: rtl/chaser_sequencer.sv
// chaser_sequencer: one-hot LED chaser driven by a valid/ready command port and a programmable tick period.
// Optional end-position bounce is compiled in when CHASER_BOUNCE_EN is defined; the default build always wraps.
module chaser_sequencer #(
  parameter int WIDTH      = 8,
  parameter int DIV_W      = 16,
  parameter int DEF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_arg,
  output logic [WIDTH-1:0] led,
  output logic             stb_out,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    OP_STOP       = 2'd0,
    OP_START      = 2'd1,
    OP_SET_PERIOD = 2'd2,
    OP_SET_DIR    = 2'd3
  } op_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             stb_q, stb_d;
  logic [WIDTH-1:0] rot_up, rot_dn;
  logic             tick;
  logic             accept;
  op_e              op;
`ifdef CHASER_BOUNCE_EN
  logic             bounce_q, bounce_d;
`endif

  assign op        = op_e'(cmd_op);
  assign tick      = (state_q == RUN) && (cnt_q == period_q);
  // Commands are refused in tick cycles so a command never coincides with a rotation.
  assign cmd_ready = !tick;
  assign accept    = cmd_valid && !tick;
  assign busy      = (state_q == RUN);
  assign led       = led_q;
  assign stb_out   = stb_q;

  assign rot_up = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
  assign rot_dn = {led_q[0], led_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= DIV_W'(DEF_PERIOD);
      dir_q    <= 1'b0;
      led_q    <= WIDTH'(1);
      stb_q    <= 1'b0;
`ifdef CHASER_BOUNCE_EN
      bounce_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      led_q    <= led_d;
      stb_q    <= stb_d;
`ifdef CHASER_BOUNCE_EN
      bounce_q <= bounce_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    dir_d    = dir_q;
    led_d    = led_q;
    stb_d    = tick;
`ifdef CHASER_BOUNCE_EN
    bounce_d = bounce_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept && op == OP_START) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          cnt_d = '0;
`ifdef CHASER_BOUNCE_EN
          // At an end position the direction flips and the pattern steps back instead of wrapping.
          if (bounce_q && !dir_q && led_q[WIDTH-1]) begin
            dir_d = 1'b1;
            led_d = rot_dn;
          end else if (bounce_q && dir_q && led_q[0]) begin
            dir_d = 1'b0;
            led_d = rot_up;
          end else begin
            led_d = dir_q ? rot_dn : rot_up;
          end
`else
          led_d = dir_q ? rot_dn : rot_up;
`endif
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (accept && op == OP_STOP) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept && op == OP_SET_PERIOD) begin
      period_d = cmd_arg;
      cnt_d    = '0;
    end

    if (accept && op == OP_SET_DIR) begin
      dir_d = cmd_arg[0];
`ifdef CHASER_BOUNCE_EN
      bounce_d = cmd_arg[1];
`endif
    end
  end

endmodule

// File: tb/tb_chaser_sequencer.sv
// Directed bench for chaser_sequencer (WIDTH=8); a WIDTH=4 instance is added when CHASER_BOUNCE_EN is defined.
module tb_chaser_sequencer;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op    = 2'd0;
  logic [15:0] cmd_arg   = 16'd0;
  logic        cmd_ready;
  logic [7:0]  led;
  logic        stb_out;
  logic        busy;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  chaser_sequencer #(.WIDTH(8), .DIV_W(16), .DEF_PERIOD(4)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .led       (led),
    .stb_out   (stb_out),
    .busy      (busy)
  );

`ifdef CHASER_BOUNCE_EN
  logic        c4_valid = 1'b0;
  logic [1:0]  c4_op    = 2'd0;
  logic [15:0] c4_arg   = 16'd0;
  logic        c4_ready;
  logic [3:0]  led4;
  logic        stb4;
  logic        busy4;

  chaser_sequencer #(.WIDTH(4), .DIV_W(16), .DEF_PERIOD(4)) u_dut4 (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (c4_valid),
    .cmd_ready (c4_ready),
    .cmd_op    (c4_op),
    .cmd_arg   (c4_arg),
    .led       (led4),
    .stb_out   (stb4),
    .busy      (busy4)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_stb(input string tag, input int budget, output int steps);
    steps = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      steps++;
      if (stb_out) break;
    end
    chk({tag, "_stb"}, 32'(stb_out), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] exp_led;

    // Reset state, held across edges
    resetn = 1'b0;
    repeat (3) step();
    chk("rst_led",   32'(led),       32'h01);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_stb",   32'(stb_out),   32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    resetn = 1'b1;
    step();
    chk("post_rst_busy",  32'(busy),      32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // START offered in cycle 0, default period 4
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    chk("c0_led", 32'(led), 32'h01);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("c%0d_led", c),   32'(led),       32'h01);
      chk($sformatf("c%0d_stb", c),   32'(stb_out),   32'd0);
      chk($sformatf("c%0d_busy", c),  32'(busy),      32'd1);
      chk($sformatf("c%0d_ready", c), 32'(cmd_ready), (c == 5) ? 32'd0 : 32'd1);
      step();
    end
    chk("c6_led", 32'(led),     32'h02);
    chk("c6_stb", 32'(stb_out), 32'd1);
    step();
    chk("c7_stb", 32'(stb_out), 32'd0);
    repeat (4) step();
    chk("c11_led", 32'(led),     32'h04);
    chk("c11_stb", 32'(stb_out), 32'd1);
    repeat (5) step();
    chk("c16_led",   32'(led),       32'h08);
    chk("c16_ready", 32'(cmd_ready), 32'd1);

    // STOP at led=0x08, then frozen
    issue(2'd0, 16'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("frozen%0d_led", i), 32'(led),     32'h08);
      chk($sformatf("frozen%0d_stb", i), 32'(stb_out), 32'd0);
      step();
    end

    // Restart and run up to led=0x01, then reverse direction
    issue(2'd1, 16'd0);
    exp_led = 8'h08;
    for (int i = 0; i < 5; i++) begin
      exp_led = {exp_led[6:0], exp_led[7]};
      wait_stb($sformatf("run%0d", i), 8, n);
      chk($sformatf("run%0d_led", i), 32'(led), 32'(exp_led));
    end
    chk("run_first_interval", 32'(n), 32'd5);
    issue(2'd3, 16'd1);
    wait_stb("dir1", 8, n);
    chk("dir1_interval", 32'(n), 32'd4);
    chk("dir1_led", 32'(led), 32'h80);
    wait_stb("dir2", 8, n);
    chk("dir2_led", 32'(led), 32'h40);

    // SET_DIR arg=2: dir=0 with bounce request
    issue(2'd3, 16'd2);
    wait_stb("bnc1", 8, n);
    chk("bnc1_led", 32'(led), 32'h80);
    wait_stb("bnc2", 8, n);
`ifdef CHASER_BOUNCE_EN
    exp_led = 8'h40;
`else
    exp_led = 8'h01;
`endif
    chk("bnc2_led", 32'(led), 32'(exp_led));
    issue(2'd0, 16'd0);
    chk("stop2_busy", 32'(busy), 32'd0);
    chk("stop2_led",  32'(led),  32'(exp_led));

    // Period 0: rotate every cycle; a held STOP must be refused
    issue(2'd3, 16'd0);
    issue(2'd2, 16'd0);
    issue(2'd1, 16'd0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("p0_%0d_ready", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("p0_%0d_busy", i),  32'(busy),      32'd1);
      chk($sformatf("p0_%0d_led", i),   32'(led),       32'(exp_led));
      if (i > 0) chk($sformatf("p0_%0d_stb", i), 32'(stb_out), 32'd1);
      exp_led = {exp_led[6:0], exp_led[7]};
      step();
    end
    cmd_valid = 1'b0;

    // Reset asserted between edges while running
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_led",  32'(led),     32'h01);
    chk("mid_rst_busy", 32'(busy),    32'd0);
    chk("mid_rst_stb",  32'(stb_out), 32'd0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("after_rst%0d_stb", i),  32'(stb_out), 32'd0);
      chk($sformatf("after_rst%0d_busy", i), 32'(busy),    32'd0);
      chk($sformatf("after_rst%0d_led", i),  32'(led),     32'h01);
    end

`ifdef CHASER_BOUNCE_EN
    begin
      logic [3:0] seq4 [7];
      seq4 = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
      c4_valid = 1'b1;
      c4_op    = 2'd3;
      c4_arg   = 16'd2;
      step();
      c4_op = 2'd1;
      step();
      c4_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
        for (int i = 0; i < 8; i++) begin
          step();
          if (stb4) break;
        end
        chk($sformatf("w4_%0d_stb", k), 32'(stb4), 32'd1);
        chk($sformatf("w4_%0d_led", k), 32'(led4), 32'(seq4[k]));
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
